seq_mult_ctrl: RTL and testbench

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

---
 rtl/seq_mult_ctrl_pkg.sv | 12 +
 rtl/seq_mult_ctrl_if.sv | 28 ++
 rtl/seq_mult_ctrl_rca.sv | 23 ++
 rtl/seq_mult_ctrl.sv | 98 +++++++++
 tb/tb_seq_mult_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
package seq_mult_ctrl_pkg;

  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Start/result handshake bundle between requester, multiplier and consumer.
interface seq_mult_ctrl_if
  import seq_mult_ctrl_pkg::*;
#(
  parameter int N = DEF_N
);
  logic           start_valid;
  logic           start_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           flush;
  logic           result_valid;
  logic           result_ready;
  logic [2*N-1:0] product;
  logic           busy;

  // Requester/consumer side
  modport master (
    output start_valid, a, b, flush, result_ready,
    input  start_ready, result_valid, product, busy
  );

  // Multiplier side
  modport slave (
    input  start_valid, a, b, flush, result_ready,
    output start_ready, result_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_ctrl_rca.sv
// N-bit ripple-carry adder producing an N+1-bit sum (carry out on top).
module rca_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N:0]   o_sum
);

  // Full-adder chain from LSB to MSB
  always_comb begin
    logic w_c;
    o_sum = '0;
    w_c   = i_cin;
    for (int i = 0; i < N; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_sum[N] = w_c;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: one shift-add step per RUN cycle, N steps.
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mult_ctrl_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  state_e          r_state, w_state_nxt;
  logic [N-1:0]    r_mcand, r_acc_hi, r_acc_lo;
  logic [CW-1:0]   r_cnt, w_cnt_inc;
  logic [N-1:0]    w_addend;
  logic [N:0]      w_sum;
  logic            w_load, w_step;

  assign w_addend    = r_acc_lo[0] ? r_mcand : '0;
  assign bus.product = {r_acc_hi, r_acc_lo};

  rca_adder #(.N(N)) u_rca (
    .i_a   (r_acc_hi),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  // Counter increment built from bit logic so the adder stays the only arithmetic
  always_comb begin
    logic w_c;
    w_cnt_inc = '0;
    w_c       = 1'b1;
    for (int i = 0; i < CW; i++) begin
      w_cnt_inc[i] = r_cnt[i] ^ w_c;
      w_c          = w_c & r_cnt[i];
    end
  end

  // Next state, datapath enables and handshake outputs; flush overrides all
  always_comb begin
    w_state_nxt      = r_state;
    w_load           = 1'b0;
    w_step           = 1'b0;
    bus.start_ready  = 1'b0;
    bus.busy         = 1'b0;
    bus.result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.busy = 1'b1;
        w_step   = 1'b1;
        if (w_cnt_inc == CW'(N)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_step      = 1'b0;
    end
  end

  // State register and accumulator; reset wins over flush and handshakes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_mcand  <= bus.a;
        r_acc_hi <= '0;
        r_acc_lo <= bus.b;
        r_cnt    <= '0;
      end else if (w_step) begin
        {r_acc_hi, r_acc_lo} <= {w_sum, r_acc_lo[N-1:1]};
        r_cnt                <= w_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and random checks of seq_mult_ctrl against a cycle-level behavioural model.
module tb_seq_mult_ctrl;
  localparam int N  = 8;
  localparam int PW = 2 * N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_mult_ctrl_if #(.N(N)) bus ();
  seq_mult_ctrl #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase + remaining-step countdown, product from a*b
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;
  int          m_ph    = M_IDLE;
  int          m_left  = 0;
  int          m_done  = 0;
  bit          m_init  = 1'b0;
  bit          m_zero  = 1'b0;
  logic [PW-1:0] m_prod = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = M_IDLE; m_prod = '0; m_zero = 1'b1; m_init = 1'b1;
    end else if (m_init) begin
      if (bus.flush) m_ph = M_IDLE;
      else begin
        case (m_ph)
          M_IDLE: if (bus.start_valid) begin
            m_prod = PW'(bus.a) * PW'(bus.b);
            m_left = N; m_ph = M_BUSY; m_zero = 1'b0;
          end
          M_BUSY: begin
            m_left--;
            if (m_left == 0) m_ph = M_DONE;
          end
          default: if (bus.result_ready) begin
            m_ph = M_IDLE; m_done++;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_init) begin
      check("cyc_start_ready",  64'(bus.start_ready),  64'(m_ph == M_IDLE));
      check("cyc_busy",         64'(bus.busy),         64'(m_ph == M_BUSY));
      check("cyc_result_valid", 64'(bus.result_valid), 64'(m_ph == M_DONE));
      if (m_ph == M_DONE || m_zero) check("cyc_product", 64'(bus.product), 64'(m_zero ? '0 : m_prod));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic [N-1:0] ia, input logic [N-1:0] ib);
    int k;
    k = 0;
    while (!bus.start_ready && k < 50) begin tick(); k++; end
    if (!bus.start_ready) check("idle_timeout", 64'(0), 64'(1));
    bus.a = ia; bus.b = ib; bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
  endtask

  // Returns at the first DONE cycle; lat counts cycles after the accepting edge
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        output logic [PW-1:0] p, output int lat);
    start(ia, ib);
    lat = 1;
    while (!bus.result_valid && lat < 50) begin tick(); lat++; end
    if (!bus.result_valid) check("done_timeout", 64'(0), 64'(1));
    p = bus.product;
  endtask

  logic [PW-1:0] p;
  int lat, target, cyc;

  initial begin
    rst_n = 1'b0;
    bus.start_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.result_ready = 1'b1;
    repeat (2) tick();
    check("rst_start_ready",  64'(bus.start_ready),  64'(1));
    check("rst_busy",         64'(bus.busy),         64'(0));
    check("rst_result_valid", 64'(bus.result_valid), 64'(0));
    check("rst_product",      64'(bus.product),      64'(0));
    rst_n = 1'b1;
    tick();

    // 13*11, latency and single-cycle DONE
    run_op(8'd13, 8'd11, p, lat);
    check("p_13x11", 64'(p), 64'd143);
    check("lat_13x11", 64'(lat), 64'd9);
    tick();
    check("rv_one_cycle", 64'(bus.result_valid), 64'(0));

    // Boundary operands
    run_op(8'hFF, 8'hFF, p, lat); check("p_ffxff", 64'(p), 64'hFE01); tick();
    run_op(8'h00, 8'hFF, p, lat); check("p_0xff",  64'(p), 64'h0);    tick();
    run_op(8'hFF, 8'h00, p, lat); check("p_ffx0",  64'(p), 64'h0);    tick();

    // Stalled consumer; start_valid in DONE and on the release edge is ignored
    bus.result_ready = 1'b0;
    run_op(8'd7, 8'd9, p, lat);
    bus.a = 8'd1; bus.b = 8'd1; bus.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_product", 64'(bus.product), 64'd63);
      check("stall_rv",      64'(bus.result_valid), 64'(1));
    end
    bus.result_ready = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    check("release_idle", 64'(bus.start_ready), 64'(1));
    tick();
    check("release_not_accepted", 64'(bus.busy), 64'(0));

    // Reset in RUN cycle 4
    start(8'd100, 8'd200);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("midrun_rst_ready",   64'(bus.start_ready), 64'(1));
    check("midrun_rst_product", 64'(bus.product),     64'(0));
    rst_n = 1'b1;
    run_op(8'd3, 8'd5, p, lat); check("p_3x5", 64'(p), 64'd15); tick();

    // Flush in RUN
    start(8'd20, 8'd30);
    repeat (2) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_run_idle", 64'(bus.start_ready), 64'(1));
    for (int i = 0; i < N + 3; i++) begin
      check("flush_run_no_rv", 64'(bus.result_valid), 64'(0));
      tick();
    end

    // Flush in DONE wins over result_ready
    bus.result_ready = 1'b0;
    run_op(8'd9, 8'd9, p, lat);
    check("p_9x9", 64'(p), 64'd81);
    target = m_done;
    bus.flush = 1'b1; bus.result_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_done_idle", 64'(bus.start_ready), 64'(1));
    check("flush_done_no_rv", 64'(bus.result_valid), 64'(0));
    check("flush_done_not_counted", 64'(m_done), 64'(target));

    // Random back-to-back ops with consumer stalls
    target = m_done + 200;
    cyc = 0;
    while (m_done < target && cyc < 20000) begin
      bus.result_ready = ($urandom_range(0, 3) != 0);
      bus.a = N'($urandom);
      bus.b = N'($urandom);
      if (bus.start_ready) bus.start_valid = 1'b1;
      else                 bus.start_valid = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    bus.start_valid = 1'b0;
    bus.result_ready = 1'b1;
    check("rand_ops_done", 64'(m_done), 64'(target));
    repeat (N + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
